bin_maxpool: RTL



---
 rtl/bin_pkg.sv | 37 +++
 rtl/bin_pool_row.sv | 24 ++
 rtl/bin_maxpool.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bin_pkg.sv
// Shared definitions for the binary max-pool stage: fixed widths, stream
// framing constants, FSM state encoding and header decode helpers.
package bin_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    // Stream framing
    localparam logic [DATA_W-1:0] HDR_END = 16'h00FF;

    // Input image dimensions accepted by the pooling stage
    localparam logic [7:0] DIM_8  = 8'd8;
    localparam logic [7:0] DIM_10 = 8'd10;
    localparam logic [7:0] DIM_14 = 8'd14;

    // One-hot controller states
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_FETCH = 5'b00010,
        S_HDR   = 5'b00100,
        S_ROWS  = 5'b01000,
        S_TERM  = 5'b10000
    } state_t;

    // True when the header dimension is one the stage can pool
    function automatic logic dim_legal(input logic [7:0] d);
        return (d == DIM_8) || (d == DIM_10) || (d == DIM_14);
    endfunction

    // Pooled dimension P = D/2 (at most 7, so 4 bits are enough)
    function automatic logic [3:0] pool_dim(input logic [7:0] d);
        logic [7:0] half;
        half = d >> 1;
        return half[3:0] | {3'b000, half[7] & 1'b0};
    endfunction

endpackage

// File: rtl/bin_pool_row.sv
// Combinational 2x2 binary max-pool of one row pair. Output bit i is the OR
// of columns 2i and 2i+1 of both rows, for i < P; higher bits are forced to 0
// so input columns at or beyond D never reach the output.
module bin_pool_row
    import bin_pkg::*;
(
    input  logic [DATA_W-1:0] even_row,
    input  logic [DATA_W-1:0] odd_row,
    input  logic [3:0]        p_dim,
    output logic [DATA_W-1:0] pooled
);

    // OR-reduce each 2x2 window, masking windows beyond the pooled width
    always_comb begin
        pooled = '0;
        for (int i = 0; i < DATA_W / 2; i++) begin
            if (4'(i) < p_dim) begin
                pooled[i] = even_row[2*i] | even_row[2*i+1] |
                            odd_row[2*i]  | odd_row[2*i+1];
            end
        end
    end

endmodule

// File: rtl/bin_maxpool.sv
// Binary 2x2/stride-2 max-pool stage. Reads framed feature maps (header D,
// then D row words) from the source SRAM and writes framed pooled maps
// (header P=D/2, then P rows) to the destination SRAM, followed by a single
// 0x00FF terminator.
//
// Reads are issued every cycle from the moment the first header address is
// presented, so the next header read naturally lands at header + D + 1 and
// overlaps the final pooled-row write with no bubble.
//
// Optional build macro: POOL_IMG_CNT_EN adds the pool_img_cnt output, the
// saturating count of legal images pooled in the current run.
module bin_maxpool
    import bin_pkg::*;
(
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] pool_rd_addr,
    input  logic [DATA_W-1:0] pool_rd_data,
    output logic [ADDR_W-1:0] pool_wr_addr,
    output logic [DATA_W-1:0] pool_wr_data,
`ifdef POOL_IMG_CNT_EN
    output logic [7:0]        pool_img_cnt,
`endif
    output logic              pool_wr_en
);

    state_t            state;
    logic [3:0]        p_dim;
    logic [2:0]        prow_cnt;
    logic              odd_ph;
    logic [DATA_W-1:0] even_row_p1;
    logic [DATA_W-1:0] pooled;
    logic [7:0]        hdr_dim;
    logic              last_prow;

    assign hdr_dim   = pool_rd_data[7:0];
    assign last_prow = ({1'b0, prow_cnt} == (p_dim - 4'd1));

    bin_pool_row u_pool_row (
        .even_row (even_row_p1),
        .odd_row  (pool_rd_data),
        .p_dim    (p_dim),
        .pooled   (pooled)
    );

    // Controller: framing, read/write address generation and write strobes
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state        <= S_IDLE;
            dut_busy     <= 1'b0;
            pool_rd_addr <= '0;
            pool_wr_addr <= '0;
            pool_wr_data <= '0;
            pool_wr_en   <= 1'b0;
            p_dim        <= '0;
            prow_cnt     <= '0;
            odd_ph       <= 1'b0;
        end else begin
            pool_wr_en <= 1'b0;
            if (pool_wr_en) begin
                pool_wr_addr <= pool_wr_addr + 12'd1;
            end
            case (state)
                S_IDLE: begin
                    if (dut_run) begin
                        dut_busy <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    pool_rd_addr <= pool_rd_addr + 12'd1;
                    state        <= S_HDR;
                end
                S_HDR: begin
                    pool_rd_addr <= pool_rd_addr + 12'd1;
                    if (dim_legal(hdr_dim)) begin
                        p_dim        <= pool_dim(hdr_dim);
                        pool_wr_data <= {12'd0, pool_dim(hdr_dim)};
                        pool_wr_en   <= 1'b1;
                        prow_cnt     <= '0;
                        odd_ph       <= 1'b0;
                        state        <= S_ROWS;
                    end else begin
                        pool_wr_data <= HDR_END;
                        pool_wr_en   <= 1'b1;
                        state        <= S_TERM;
                    end
                end
                S_ROWS: begin
                    pool_rd_addr <= pool_rd_addr + 12'd1;
                    if (!odd_ph) begin
                        odd_ph <= 1'b1;
                    end else begin
                        odd_ph       <= 1'b0;
                        pool_wr_data <= pooled;
                        pool_wr_en   <= 1'b1;
                        if (last_prow) begin
                            prow_cnt <= '0;
                            state    <= S_HDR;
                        end else begin
                            prow_cnt <= prow_cnt + 3'd1;
                        end
                    end
                end
                S_TERM: begin
                    dut_busy     <= 1'b0;
                    pool_rd_addr <= '0;
                    pool_wr_addr <= '0;
                    state        <= S_IDLE;
                end
                default: begin
                    dut_busy     <= 1'b0;
                    pool_rd_addr <= '0;
                    pool_wr_addr <= '0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

    // Even-row latch: holds row 2j until row 2j+1 arrives
    always_ff @(posedge clk) begin
        if ((state == S_ROWS) && !odd_ph) begin
            even_row_p1 <= pool_rd_data;
        end
    end

`ifdef POOL_IMG_CNT_EN
    // Saturating count of legal image headers written during this run
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pool_img_cnt <= '0;
        end else if ((state == S_IDLE) && dut_run) begin
            pool_img_cnt <= '0;
        end else if ((state == S_HDR) && dim_legal(hdr_dim) && (pool_img_cnt != 8'hFF)) begin
            pool_img_cnt <= pool_img_cnt + 8'd1;
        end
    end
`endif

endmodule
